alu_bist_sched: RTL and testbench

//  Owns the operand/control inputs of the 5-way voted ALU (alu). Passes datapath ops through with

---
 rtl/alu_bist_sched.sv | 239 +++++++++++++++++++++++
 tb/tb_alu_bist_sched.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_bist_sched.sv
`default_nettype none
// ============================================================================
//  Module   : alu_bist_sched
//  Purpose  : Arbitrates the operand/control inputs of the voted ALU between
//             the MIPS datapath (always has priority) and a built-in
//             self-test sweep of 8 fixed vectors. The sweep is launched
//             after the ALU has sat idle for IDLE_CYCLES cycles. Voted-result
//             mismatches are counted (saturating) and latched into a sticky
//             fault flag.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk         in   1      clock, all state changes on rising edge
//    reset       in   1      synchronous reset, active low
//    req_valid   in   1      datapath ALU request
//    req_a/b     in   32     datapath operands
//    req_cont    in   3      datapath alucont
//    req_ready   out  1      request accepted when req_valid & req_ready
//    rsp_valid   out  1      registered response strobe (latency 1)
//    rsp_result  out  32     registered ALU result of accepted request
//    rsp_zero    out  1      registered ALU zero of accepted request
//    alu_a/b     out  32     ALU operands (combinational)
//    alu_cont    out  3      ALU alucont (combinational)
//    alu_result  in   32     ALU voted result
//    alu_zero    in   1      ALU voted zero flag
//    test_en     in   1      enables idle counting and self-test
//    clr_fault   in   1      clears fault and fail_count
//    test_busy   out  1      self-test sweep in progress
//    vec_idx     out  3      current/next self-test vector index
//    sweep_done  out  1      one-cycle pulse after vector 7 was checked
//    fail_count  out  CNT_W  saturating mismatch count
//    fault       out  1      sticky mismatch flag
// ============================================================================
module alu_bist_sched #(
    parameter int IDLE_CYCLES = 16,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    input  logic [2:0]       req_cont,
    output logic             req_ready,
    output logic             rsp_valid,
    output logic [31:0]      rsp_result,
    output logic             rsp_zero,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic [2:0]       alu_cont,
    input  logic [31:0]      alu_result,
    input  logic             alu_zero,
    input  logic             test_en,
    input  logic             clr_fault,
    output logic             test_busy,
    output logic [2:0]       vec_idx,
    output logic             sweep_done,
    output logic [CNT_W-1:0] fail_count,
    output logic             fault
);

    // The idle counter only needs to reach IDLE_CYCLES-1: the cycle in which
    // it already holds that value is the last idle cycle before the sweep.
    localparam int              c_IDLE_W    = (IDLE_CYCLES < 2) ? 1 : $clog2(IDLE_CYCLES);
    localparam logic [c_IDLE_W-1:0] c_IDLE_LAST = c_IDLE_W'(IDLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]    c_CNT_MAX   = {CNT_W{1'b1}};

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_BIST = 1'b1;

    logic [0:0]          r_state;
    logic [0:0]          w_state_next;
    logic [c_IDLE_W-1:0] r_idle_cnt;
    logic [2:0]          r_vec_idx;
    logic                r_rsp_valid;
    logic [31:0]         r_rsp_result;
    logic                r_rsp_zero;
    logic                r_sweep_done;
    logic [CNT_W-1:0]    r_fail_count;
    logic                r_fault;

    logic [31:0]         w_vec_a;
    logic [31:0]         w_vec_b;
    logic [2:0]          w_vec_cont;
    logic [31:0]         w_gold_result;
    logic                w_gold_zero;
    logic                w_in_bist;
    logic                w_idle_hit;
    logic                w_mismatch;

    // ------------------------------------------------------------------
    // Self-test vector ROM with golden responses
    // ------------------------------------------------------------------
    always_comb begin
        w_vec_a       = 32'd0;
        w_vec_b       = 32'd0;
        w_vec_cont    = 3'b000;
        w_gold_result = 32'd0;
        w_gold_zero   = 1'b0;
        case (r_vec_idx)
            3'd0: begin w_vec_a = 32'h0000_0005; w_vec_b = 32'h0000_0003; w_vec_cont = 3'b010;
                        w_gold_result = 32'h0000_0008; w_gold_zero = 1'b0; end
            3'd1: begin w_vec_a = 32'h0000_0005; w_vec_b = 32'h0000_0005; w_vec_cont = 3'b110;
                        w_gold_result = 32'h0000_0000; w_gold_zero = 1'b1; end
            3'd2: begin w_vec_a = 32'hFFFF_0000; w_vec_b = 32'h0F0F_0F0F; w_vec_cont = 3'b000;
                        w_gold_result = 32'h0F0F_0000; w_gold_zero = 1'b0; end
            3'd3: begin w_vec_a = 32'hFFFF_0000; w_vec_b = 32'h0000_FFFF; w_vec_cont = 3'b001;
                        w_gold_result = 32'hFFFF_FFFF; w_gold_zero = 1'b0; end
            3'd4: begin w_vec_a = 32'h0000_0003; w_vec_b = 32'h0000_0007; w_vec_cont = 3'b111;
                        w_gold_result = 32'h0000_0001; w_gold_zero = 1'b0; end
            3'd5: begin w_vec_a = 32'h0000_0007; w_vec_b = 32'h0000_0003; w_vec_cont = 3'b111;
                        w_gold_result = 32'h0000_0000; w_gold_zero = 1'b1; end
            3'd6: begin w_vec_a = 32'hFFFF_FFFF; w_vec_b = 32'h0000_0001; w_vec_cont = 3'b010;
                        w_gold_result = 32'h0000_0000; w_gold_zero = 1'b1; end
            default: begin w_vec_a = 32'h8000_0000; w_vec_b = 32'h0000_0001; w_vec_cont = 3'b110;
                        w_gold_result = 32'h7FFF_FFFF; w_gold_zero = 1'b0; end
        endcase
    end

    assign w_in_bist  = (r_state == c_ST_BIST);
    assign w_idle_hit = (r_state == c_ST_IDLE) && test_en && !req_valid
                        && (r_idle_cnt == c_IDLE_LAST);
    assign w_mismatch = w_in_bist
                        && ((alu_result != w_gold_result) || (alu_zero != w_gold_zero));

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state. A request or test disable during a sweep still lets
    // the current vector be checked, then hands the ALU back next cycle.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_idle_hit) begin
                    w_state_next = c_ST_BIST;
                end
            end
            c_ST_BIST: begin
                if ((r_vec_idx == 3'd7) || req_valid || !test_en) begin
                    w_state_next = c_ST_IDLE;
                end
            end
            default: w_state_next = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs (ALU input mux and handshake)
    // ------------------------------------------------------------------
    always_comb begin
        req_ready = 1'b0;
        alu_a     = req_a;
        alu_b     = req_b;
        alu_cont  = req_cont;
        case (r_state)
            c_ST_BIST: begin
                alu_a    = w_vec_a;
                alu_b    = w_vec_b;
                alu_cont = w_vec_cont;
            end
            default: begin
                req_ready = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Response capture, idle counter, vector index and fault bookkeeping
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_idle_cnt   <= '0;
            r_vec_idx    <= 3'd0;
            r_rsp_valid  <= 1'b0;
            r_rsp_result <= 32'd0;
            r_rsp_zero   <= 1'b0;
            r_sweep_done <= 1'b0;
            r_fail_count <= '0;
            r_fault      <= 1'b0;
        end else begin
            r_rsp_valid  <= 1'b0;
            r_sweep_done <= 1'b0;

            if (w_in_bist) begin
                r_idle_cnt <= '0;
                // Index always advances so an interrupted sweep resumes at
                // the vector after the last one checked.
                r_vec_idx  <= r_vec_idx + 3'd1;
                if (r_vec_idx == 3'd7) begin
                    r_sweep_done <= 1'b1;
                end
            end else begin
                if (req_valid) begin
                    r_rsp_valid  <= 1'b1;
                    r_rsp_result <= alu_result;
                    r_rsp_zero   <= alu_zero;
                end
                if (test_en && !req_valid && !w_idle_hit) begin
                    r_idle_cnt <= r_idle_cnt + c_IDLE_W'(1);
                end else begin
                    r_idle_cnt <= '0;
                end
            end

            // A clear coinciding with a mismatch leaves exactly that mismatch recorded.
            if (clr_fault) begin
                r_fault      <= w_mismatch;
                r_fail_count <= w_mismatch ? CNT_W'(1) : '0;
            end else if (w_mismatch) begin
                r_fault <= 1'b1;
                if (r_fail_count != c_CNT_MAX) begin
                    r_fail_count <= r_fail_count + CNT_W'(1);
                end
            end
        end
    end

    assign rsp_valid  = r_rsp_valid;
    assign rsp_result = r_rsp_result;
    assign rsp_zero   = r_rsp_zero;
    assign test_busy  = w_in_bist;
    assign vec_idx    = r_vec_idx;
    assign sweep_done = r_sweep_done;
    assign fail_count = r_fail_count;
    assign fault      = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_alu_bist_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_bist_sched
//  Purpose  : Self-checking bench for alu_bist_sched. A behavioural MIPS ALU
//             model closes the loop; a second instance with CNT_W=2 and a
//             stuck-at-zero ALU exercises count saturation and clear races.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_bist_sched;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- primary DUT (defaults) ----------------
    logic        reset, req_valid, test_en, clr_fault;
    logic [31:0] req_a, req_b;
    logic [2:0]  req_cont;
    logic        req_ready, rsp_valid, rsp_zero, test_busy, sweep_done, fault;
    logic [31:0] rsp_result, alu_a, alu_b, alu_result;
    logic [2:0]  alu_cont, vec_idx;
    logic        alu_zero;
    logic [7:0]  fail_count;

    logic        flip_en;
    logic [2:0]  flip_idx;

    alu_bist_sched dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_cont(req_cont), .req_ready(req_ready), .rsp_valid(rsp_valid),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .alu_a(alu_a), .alu_b(alu_b),
        .alu_cont(alu_cont), .alu_result(alu_result), .alu_zero(alu_zero),
        .test_en(test_en), .clr_fault(clr_fault), .test_busy(test_busy),
        .vec_idx(vec_idx), .sweep_done(sweep_done), .fail_count(fail_count), .fault(fault)
    );

    function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] c);
        case (c)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b010:  return a + b;
            3'b110:  return a - b;
            3'b111:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    logic [31:0] model_res;
    always_comb begin
        model_res  = alu_f(alu_a, alu_b, alu_cont);
        alu_zero   = (model_res == 32'd0);
        alu_result = model_res ^ {31'd0, (flip_en && test_busy && (vec_idx == flip_idx))};
    end

    // ---------------- second DUT: CNT_W=2, stuck ALU ----------------
    logic        req_valid2, test_en2, clr2;
    logic        req_ready2, rsp_valid2, rsp_zero2, busy2, done2, fault2;
    logic [31:0] rsp_result2, alu_a2, alu_b2;
    logic [2:0]  alu_cont2, vec_idx2;
    logic [1:0]  fail2;

    alu_bist_sched #(.IDLE_CYCLES(2), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .req_valid(req_valid2), .req_a(32'd0), .req_b(32'd0),
        .req_cont(3'd0), .req_ready(req_ready2), .rsp_valid(rsp_valid2),
        .rsp_result(rsp_result2), .rsp_zero(rsp_zero2), .alu_a(alu_a2), .alu_b(alu_b2),
        .alu_cont(alu_cont2), .alu_result(32'd0), .alu_zero(1'b1),
        .test_en(test_en2), .clr_fault(clr2), .test_busy(busy2),
        .vec_idx(vec_idx2), .sweep_done(done2), .fail_count(fail2), .fault(fault2)
    );

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_busy(input int limit);
        bit ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (test_busy) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        chk("wait_bist_start", {31'd0, ok}, 32'd1);
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  cont;
        logic [31:0] res;
        logic        zero;
    } vec_t;

    vec_t        tbl[5];
    logic [31:0] exp_va[8];
    logic [2:0]  exp_vc[8];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int sweeps;
        bit ok;

        tbl[0] = '{32'h0000_0005, 32'h0000_0003, 3'b010, 32'h0000_0008, 1'b0};
        tbl[1] = '{32'h0000_0005, 32'h0000_0005, 3'b110, 32'h0000_0000, 1'b1};
        tbl[2] = '{32'hFFFF_0000, 32'h0F0F_0F0F, 3'b000, 32'h0F0F_0000, 1'b0};
        tbl[3] = '{32'h0000_0001, 32'h0000_0002, 3'b111, 32'h0000_0001, 1'b0};
        tbl[4] = '{32'hA5A5_A5A5, 32'h5A5A_5A5A, 3'b001, 32'hFFFF_FFFF, 1'b0};
        exp_va = '{32'h5, 32'h5, 32'hFFFF_0000, 32'hFFFF_0000, 32'h3, 32'h7, 32'hFFFF_FFFF, 32'h8000_0000};
        exp_vc = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111, 3'b111, 3'b010, 3'b110};

        reset = 1'b0; req_valid = 1'b1; req_a = 32'd5; req_b = 32'd3; req_cont = 3'b010;
        test_en = 1'b1; clr_fault = 1'b0; flip_en = 1'b0; flip_idx = 3'd0;
        req_valid2 = 1'b0; test_en2 = 1'b0; clr2 = 1'b0;

        // 1. reset held two cycles with a request pending
        step(); step();
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_fault", {31'd0, fault}, 32'd0);
        chk("rst_fail_count", {24'd0, fail_count}, 32'd0);
        chk("rst_test_busy", {31'd0, test_busy}, 32'd0);
        chk("rst_vec_idx", {29'd0, vec_idx}, 32'd0);
        chk("rst_sweep_done", {31'd0, sweep_done}, 32'd0);

        // 2. datapath passthrough, table driven
        reset = 1'b1; test_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1; req_a = tbl[i].a; req_b = tbl[i].b; req_cont = tbl[i].cont;
            #1;
            chk($sformatf("pass_alu_a[%0d]", i), alu_a, tbl[i].a);
            chk($sformatf("pass_alu_cont[%0d]", i), {29'd0, alu_cont}, {29'd0, tbl[i].cont});
            chk($sformatf("pass_ready[%0d]", i), {31'd0, req_ready}, 32'd1);
            step();
            chk($sformatf("rsp_valid[%0d]", i), {31'd0, rsp_valid}, 32'd1);
            chk($sformatf("rsp_result[%0d]", i), rsp_result, tbl[i].res);
            chk($sformatf("rsp_zero[%0d]", i), {31'd0, rsp_zero}, {31'd0, tbl[i].zero});
        end
        req_valid = 1'b0;
        step();
        chk("rsp_valid_idle", {31'd0, rsp_valid}, 32'd0);

        // 3. clean sweep after exactly 16 idle cycles
        test_en = 1'b1;
        repeat (15) step();
        chk("busy_before_16_idle", {31'd0, test_busy}, 32'd0);
        step();
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("sweep_busy[%0d]", k), {31'd0, test_busy}, 32'd1);
            chk($sformatf("sweep_idx[%0d]", k), {29'd0, vec_idx}, k);
            chk($sformatf("sweep_alu_a[%0d]", k), alu_a, exp_va[k]);
            chk($sformatf("sweep_alu_cont[%0d]", k), {29'd0, alu_cont}, {29'd0, exp_vc[k]});
            chk($sformatf("sweep_ready[%0d]", k), {31'd0, req_ready}, 32'd0);
            chk($sformatf("sweep_done_early[%0d]", k), {31'd0, sweep_done}, 32'd0);
            step();
        end
        chk("sweep_exit_busy", {31'd0, test_busy}, 32'd0);
        chk("sweep_done_pulse", {31'd0, sweep_done}, 32'd1);
        chk("sweep_idx_wrap", {29'd0, vec_idx}, 32'd0);
        chk("sweep_clean_fails", {24'd0, fail_count}, 32'd0);
        chk("sweep_clean_fault", {31'd0, fault}, 32'd0);
        step();
        chk("sweep_done_one_cycle", {31'd0, sweep_done}, 32'd0);

        // 4. single-bit corruption on vector 2
        flip_idx = 3'd2; flip_en = 1'b1;
        wait_busy(40);
        n = 0;
        while (test_busy && n < 20) begin n++; step(); end
        chk("flip_sweep_len", n, 32'd8);
        chk("flip_sweep_done", {31'd0, sweep_done}, 32'd1);
        chk("flip_fail_count", {24'd0, fail_count}, 32'd1);
        chk("flip_fault", {31'd0, fault}, 32'd1);
        flip_en = 1'b0;

        // clear with no mismatch in flight
        clr_fault = 1'b1; step(); clr_fault = 1'b0;
        chk("clr_fail_count", {24'd0, fail_count}, 32'd0);
        chk("clr_fault", {31'd0, fault}, 32'd0);

        // 5. request arrives while vector 3 is applied
        flip_idx = 3'd3; flip_en = 1'b1;
        wait_busy(40);
        step(); step(); step();
        chk("int_idx3", {29'd0, vec_idx}, 32'd3);
        req_valid = 1'b1; req_a = 32'd7; req_b = 32'd2; req_cont = 3'b110;
        #1;
        chk("int_ready_low", {31'd0, req_ready}, 32'd0);
        step();
        flip_en = 1'b0;
        chk("int_back_idle", {31'd0, test_busy}, 32'd0);
        chk("int_ready_high", {31'd0, req_ready}, 32'd1);
        chk("int_idx_kept", {29'd0, vec_idx}, 32'd4);
        chk("int_vec3_checked", {24'd0, fail_count}, 32'd1);
        chk("int_no_rsp_yet", {31'd0, rsp_valid}, 32'd0);
        step();
        req_valid = 1'b0;
        chk("int_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("int_rsp_result", rsp_result, 32'd5);
        wait_busy(40);
        chk("resume_idx", {29'd0, vec_idx}, 32'd4);
        n = 0;
        while (test_busy && n < 20) begin n++; step(); end
        chk("resume_len", n, 32'd4);
        chk("resume_done", {31'd0, sweep_done}, 32'd1);
        chk("resume_fail_count", {24'd0, fail_count}, 32'd1);

        // 6. saturation and clear/mismatch race on the 2-bit counter
        test_en2 = 1'b1;
        sweeps = 0;
        for (int i = 0; i < 80 && sweeps < 2; i++) begin
            step();
            if (done2) sweeps++;
        end
        chk("sat_sweeps", sweeps, 32'd2);
        chk("sat_fail_count", {30'd0, fail2}, 32'd3);
        chk("sat_fault", {31'd0, fault2}, 32'd1);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (busy2 && vec_idx2 == 3'd0) begin ok = 1'b1; break; end
            step();
        end
        chk("race_reach_vec0", {31'd0, ok}, 32'd1);
        clr2 = 1'b1; step(); clr2 = 1'b0; test_en2 = 1'b0;
        chk("race_fail_count", {30'd0, fail2}, 32'd1);
        chk("race_fault", {31'd0, fault2}, 32'd1);
        step(); step();
        chk("race_disable_idle", {31'd0, busy2}, 32'd0);
        clr2 = 1'b1; step(); clr2 = 1'b0;
        chk("idle_clr_fail_count", {30'd0, fail2}, 32'd0);
        chk("idle_clr_fault", {31'd0, fault2}, 32'd0);

        // 7. reset in the middle of a sweep
        wait_busy(40);
        step(); step();
        reset = 1'b0; step(); reset = 1'b1;
        chk("midrst_busy", {31'd0, test_busy}, 32'd0);
        chk("midrst_idx", {29'd0, vec_idx}, 32'd0);
        chk("midrst_fail_count", {24'd0, fail_count}, 32'd0);
        chk("midrst_fault", {31'd0, fault}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
